// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute stage that sits after the ALU control decoder.
// Computes the ALU result and the zero, signed-overflow and illegal-op flags
// for each accepted entry, then registers it into the EX/MEM boundary behind
// a valid/ready handshake with a 2-entry skid buffer (output register O and
// skid register S). in_ready is registered, so back-pressure from MEM never
// forms a combinational path to the upstream stage.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   flush             synchronous flush; drops held and incoming entries
//   in_valid/in_ready upstream handshake (in_ready is registered)
//   in_alu_op         4-bit ALU operation code
//   in_a, in_b        operands A (rs) and B (rt or immediate)
//   in_shamt          shift amount
//   in_tag            destination tag, carried through unchanged
//   out_valid/out_ready downstream handshake
//   out_result        ALU result
//   out_zero          out_result == 0
//   out_ovf           signed overflow (ADD/SUB only)
//   out_illegal       operation code was not a supported code
//   out_tag           tag of the entry on the output
module alu_exec_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_alu_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [4:0]        in_shamt,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic              out_ovf,
    output logic              out_illegal,
    output logic [TAG_W-1:0]  out_tag
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_NOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_CMP  = 4'h8,
        ALU_CMPU = 4'h9
    } alu_op_e;

    // ------------------------------------------------------------------
    // ALU datapath
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] alu_result;
    logic              alu_ovf;
    logic              alu_illegal;
    logic              alu_zero;

    always_comb begin
        alu_result  = '0;
        alu_ovf     = 1'b0;
        alu_illegal = 1'b0;
        case (alu_op_e'(in_alu_op))
            ALU_ADD: begin
                alu_result = in_a + in_b;
                alu_ovf    = (in_a[DATA_W-1] == in_b[DATA_W-1]) &&
                             (alu_result[DATA_W-1] != in_a[DATA_W-1]);
            end
            ALU_SUB: begin
                alu_result = in_a - in_b;
                alu_ovf    = (in_a[DATA_W-1] != in_b[DATA_W-1]) &&
                             (alu_result[DATA_W-1] != in_a[DATA_W-1]);
            end
            ALU_AND:  alu_result = in_a & in_b;
            ALU_OR:   alu_result = in_a | in_b;
            ALU_NOR:  alu_result = ~(in_a | in_b);
            ALU_SLL:  alu_result = in_b << in_shamt;
            ALU_SRL:  alu_result = in_b >> in_shamt;
            ALU_SRA:  alu_result = DATA_W'($signed(in_b) >>> in_shamt);
            ALU_CMP:  alu_result = {{(DATA_W-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            ALU_CMPU: alu_result = {{(DATA_W-1){1'b0}}, (in_a < in_b)};
            default:  alu_illegal = 1'b1;
        endcase
        alu_zero = (alu_result == '0);
    end

    // ------------------------------------------------------------------
    // Skid buffer control
    // ------------------------------------------------------------------
    logic              s_valid;
    logic [DATA_W-1:0] s_result;
    logic              s_zero;
    logic              s_ovf;
    logic              s_illegal;
    logic [TAG_W-1:0]  s_tag;

    logic accept;
    logic o_free;
    logic o_load_new;
    logic o_load_skid;
    logic s_load;
    logic out_valid_nxt;
    logic s_valid_nxt;

    assign accept = in_valid && in_ready;
    assign o_free = !out_valid || out_ready;

    always_comb begin
        o_load_new    = 1'b0;
        o_load_skid   = 1'b0;
        s_load        = 1'b0;
        out_valid_nxt = out_valid;
        s_valid_nxt   = s_valid;
        if (flush) begin
            out_valid_nxt = 1'b0;
            s_valid_nxt   = 1'b0;
        end else if (s_valid) begin
            // S is older than anything arriving now, so it always refills O
            // first; a same-cycle accept lands behind it in S.
            if (out_ready) begin
                o_load_skid   = 1'b1;
                out_valid_nxt = 1'b1;
                if (accept) begin
                    s_load = 1'b1;
                end else begin
                    s_valid_nxt = 1'b0;
                end
            end
        end else if (o_free) begin
            o_load_new    = accept;
            out_valid_nxt = accept;
        end else if (accept) begin
            s_load      = 1'b1;
            s_valid_nxt = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_zero    <= 1'b0;
            out_ovf     <= 1'b0;
            out_illegal <= 1'b0;
            out_tag     <= '0;
            s_valid     <= 1'b0;
            s_result    <= '0;
            s_zero      <= 1'b0;
            s_ovf       <= 1'b0;
            s_illegal   <= 1'b0;
            s_tag       <= '0;
            in_ready    <= 1'b1;
        end else begin
            out_valid <= out_valid_nxt;
            s_valid   <= s_valid_nxt;
            in_ready  <= !s_valid_nxt;
            if (o_load_new) begin
                out_result  <= alu_result;
                out_zero    <= alu_zero;
                out_ovf     <= alu_ovf;
                out_illegal <= alu_illegal;
                out_tag     <= in_tag;
            end else if (o_load_skid) begin
                out_result  <= s_result;
                out_zero    <= s_zero;
                out_ovf     <= s_ovf;
                out_illegal <= s_illegal;
                out_tag     <= s_tag;
            end
            if (s_load) begin
                s_result  <= alu_result;
                s_zero    <= alu_zero;
                s_ovf     <= alu_ovf;
                s_illegal <= alu_illegal;
                s_tag     <= in_tag;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_NOR  = 4'h4;
    localparam logic [3:0] OP_SLL  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_SRA  = 4'h7;
    localparam logic [3:0] OP_CMP  = 4'h8;
    localparam logic [3:0] OP_CMPU = 4'h9;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_alu_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_shamt;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_ovf;
    logic        out_illegal;
    logic [4:0]  out_tag;

    int unsigned checks = 0;
    int unsigned errors = 0;

    alu_exec_stage #(.DATA_W(32), .TAG_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_alu_op  (in_alu_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_shamt   (in_shamt),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_ovf    (out_ovf),
        .out_illegal(out_illegal),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [4:0] tg);
        in_valid  = 1'b1;
        in_alu_op = op;
        in_a      = a;
        in_b      = b;
        in_shamt  = sh;
        in_tag    = tg;
    endtask

    task automatic check_out(input string tag, input logic [31:0] res, input logic z,
                             input logic ov, input logic ill, input logic [4:0] tg);
        check({tag, ".valid"},   {31'b0, out_valid},   32'd1);
        check({tag, ".result"},  out_result,           res);
        check({tag, ".zero"},    {31'b0, out_zero},    {31'b0, z});
        check({tag, ".ovf"},     {31'b0, out_ovf},     {31'b0, ov});
        check({tag, ".illegal"}, {31'b0, out_illegal}, {31'b0, ill});
        check({tag, ".tag"},     {27'b0, out_tag},     {27'b0, tg});
    endtask

    // Stream vectors: op, a, b, shamt, tag, expected result, zero, ovf
    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [4:0]  tg;
        logic [31:0] res;
        logic        z;
        logic        ov;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{OP_SUB,  32'd5,          32'd5,          5'd0, 5'd10, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{OP_SRA,  32'd0,          32'h8000_0000,  5'd4, 5'd11, 32'hF800_0000, 1'b0, 1'b0};
        vecs[2] = '{OP_CMP,  32'hFFFF_FFFF,  32'd1,          5'd0, 5'd12, 32'h0000_0001, 1'b0, 1'b0};
        vecs[3] = '{OP_CMPU, 32'hFFFF_FFFF,  32'd1,          5'd0, 5'd13, 32'h0000_0000, 1'b1, 1'b0};
        vecs[4] = '{OP_AND,  32'hF0F0_1234,  32'h0FF0_FF00,  5'd0, 5'd14, 32'h00F0_1200, 1'b0, 1'b0};
        vecs[5] = '{OP_OR,   32'hF000_0000,  32'h0000_000F,  5'd0, 5'd15, 32'hF000_000F, 1'b0, 1'b0};
        vecs[6] = '{OP_SRL,  32'd0,          32'h8000_0000,  5'd4, 5'd16, 32'h0800_0000, 1'b0, 1'b0};
        vecs[7] = '{OP_SUB,  32'h8000_0000,  32'd1,          5'd0, 5'd17, 32'h7FFF_FFFF, 1'b0, 1'b1};

        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; in_alu_op = '0; in_a = '0; in_b = '0; in_shamt = '0; in_tag = '0;

        // Reset state
        @(negedge clk);
        check("rst.out_valid", {31'b0, out_valid}, 32'd0);
        check("rst.in_ready",  {31'b0, in_ready},  32'd1);
        check("rst.result",    out_result,         32'd0);
        check("rst.flags",     {29'b0, out_zero, out_ovf, out_illegal}, 32'd0);
        check("rst.tag",       {27'b0, out_tag},   32'd0);
        rst_n = 1'b1;

        // Single ADD with overflow
        @(negedge clk);
        drive(OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0, 5'd3);
        @(negedge clk);
        in_valid = 1'b0;
        check_out("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 5'd3);

        // Back-to-back stream, one result per cycle
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check_out($sformatf("stream%0d", i - 1), vecs[i-1].res, vecs[i-1].z,
                          vecs[i-1].ov, 1'b0, vecs[i-1].tg);
                check($sformatf("stream%0d.in_ready", i - 1), {31'b0, in_ready}, 32'd1);
            end
            if (i < 8) drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].tg);
            else       in_valid = 1'b0;
        end
        @(negedge clk);
        check("stream.drained", {31'b0, out_valid}, 32'd0);

        // Back-pressure: O holds NOR, S holds SLL
        out_ready = 1'b0;
        drive(OP_NOR, 32'd0, 32'd0, 5'd0, 5'd20);
        @(negedge clk);
        check_out("hold.o1", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 5'd20);
        check("hold.in_ready1", {31'b0, in_ready}, 32'd1);
        drive(OP_SLL, 32'd0, 32'd1, 5'd31, 5'd21);
        @(negedge clk);
        in_valid = 1'b0;
        check_out("hold.o2", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 5'd20);
        check("hold.in_ready2", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        check_out("hold.o3", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 5'd20);
        check("hold.in_ready3", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check_out("hold.skid", 32'h8000_0000, 1'b0, 1'b0, 1'b0, 5'd21);
        check("hold.in_ready4", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        check("hold.drained", {31'b0, out_valid}, 32'd0);

        // Flush with O and S full and in_valid high
        out_ready = 1'b0;
        drive(OP_ADD, 32'd1, 32'd1, 5'd0, 5'd1);
        @(negedge clk);
        drive(OP_ADD, 32'd2, 32'd2, 5'd0, 5'd2);
        @(negedge clk);
        check("flush.pre_valid", {31'b0, out_valid}, 32'd1);
        check("flush.pre_ready", {31'b0, in_ready},  32'd0);
        drive(OP_ADD, 32'd3, 32'd3, 5'd0, 5'd4);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("flush.valid", {31'b0, out_valid}, 32'd0);
        check("flush.ready", {31'b0, in_ready},  32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("flush.quiet%0d", i), {31'b0, out_valid}, 32'd0);
        end

        // Illegal op code
        drive(4'hF, 32'h0000_1234, 32'h0000_1234, 5'd0, 5'd9);
        @(negedge clk);
        in_valid = 1'b0;
        check_out("illegal", 32'd0, 1'b1, 1'b0, 1'b1, 5'd9);
        @(negedge clk);

        // Asynchronous reset mid-stream with back-pressure
        out_ready = 1'b0;
        drive(OP_ADD, 32'd7, 32'd7, 5'd0, 5'd5);
        @(negedge clk);
        drive(OP_ADD, 32'd8, 32'd8, 5'd0, 5'd6);
        @(negedge clk);
        in_valid = 1'b0;
        check("arst.pre_valid", {31'b0, out_valid}, 32'd1);
        check("arst.pre_ready", {31'b0, in_ready},  32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst.valid",  {31'b0, out_valid}, 32'd0);
        check("arst.ready",  {31'b0, in_ready},  32'd1);
        check("arst.result", out_result,         32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        drive(OP_SUB, 32'd10, 32'd3, 5'd0, 5'd7);
        @(negedge clk);
        in_valid = 1'b0;
        check_out("post_rst", 32'd7, 1'b0, 1'b0, 1'b0, 5'd7);
        check("post_rst.ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        check("post_rst.drained", {31'b0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
